// File: rtl/uart_transmit.sv
// -----------------------------------------------------------------------------
// uart_transmit
//   Byte-wide UART transmitter with an internal TX FIFO.
//   Frame: 1 start bit (low), 8 data bits LSB first, optional even parity,
//   1 stop bit (high). Each bit lasts clk_div clk cycles, with clk_div
//   sampled when the frame starts (0 is treated as 1).
//
//   Build option:
//     UART_TX_PARITY_EN - when defined, an even-parity bit is sent between
//                         the last data bit and the stop bit.
// -----------------------------------------------------------------------------

// Small synchronous FIFO; occupancy is kept in a registered count so the
// full/empty flags are clean compares against that register.
module uart_transmit_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A write while full is dropped even if a pop happens in the same cycle.
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// -----------------------------------------------------------------------------
// Transmit FSM
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | line high, waiting for a queued byte
//   START  | start bit (line low) for one bit time
//   DATA   | 8 data bits, LSB first, one bit time each
//   PARITY | even parity of the byte (only with UART_TX_PARITY_EN)
//   STOP   | stop bit (line high); chains straight into START if more queued
// -----------------------------------------------------------------------------
module uart_transmit #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] clk_div,
  input  logic [7:0]  tx_data,
  input  logic        i_tx_valid,
  output logic        tx,
  output logic        busy,
  output logic        irq,
  output logic        o_tx_full,
  output logic        o_tx_empty
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  state;
  logic [31:0] div_lat;
  logic [31:0] bit_tmr;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tx_r;
  logic        irq_r;
`ifdef UART_TX_PARITY_EN
  logic        par_r;
`endif

  logic [7:0]  fifo_rd_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        bit_done;
  logic [31:0] div_eff;

  uart_transmit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (i_tx_valid),
    .wr_data (tx_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A zero divisor would stall the bit timer, so it is promoted to one.
  assign div_eff = (clk_div == 32'd0) ? 32'd1 : clk_div;

  // Bit timer counts down from div-1; terminal count ends the current bit.
  assign bit_done = (bit_tmr == 32'd0);

  // Pop the head when idle, or at the end of a stop bit for a gapless chain.
  assign fifo_pop = ~fifo_empty &
                    ((state == S_IDLE) | ((state == S_STOP) & bit_done));

  // Frame sequencer: state, line driver, bit timer and drain interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_lat <= 32'd0;
      bit_tmr <= 32'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      tx_r    <= 1'b1;
      irq_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      irq_r <= 1'b0;
      if (fifo_pop) begin
        // Latch byte and divisor together so later clk_div writes wait
        // for the next frame.
        state   <= S_START;
        tx_r    <= 1'b0;
        shreg   <= fifo_rd_data;
        div_lat <= div_eff;
        bit_tmr <= div_eff - 32'd1;
        bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
        par_r   <= ^fifo_rd_data;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            tx_r <= 1'b1;
          end
          S_START: begin
            if (bit_done) begin
              state   <= S_DATA;
              tx_r    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= 3'd0;
              bit_tmr <= div_lat - 32'd1;
            end else begin
              bit_tmr <= bit_tmr - 32'd1;
            end
          end
          S_DATA: begin
            if (bit_done) begin
              bit_tmr <= div_lat - 32'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state <= S_PARITY;
                tx_r  <= par_r;
`else
                state <= S_STOP;
                tx_r  <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + 3'd1;
                tx_r    <= shreg[0];
                shreg   <= shreg >> 1;
              end
            end else begin
              bit_tmr <= bit_tmr - 32'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (bit_done) begin
              state   <= S_STOP;
              tx_r    <= 1'b1;
              bit_tmr <= div_lat - 32'd1;
            end else begin
              bit_tmr <= bit_tmr - 32'd1;
            end
          end
`endif
          S_STOP: begin
            if (bit_done) begin
              // Nothing left to chain into: the queue has drained.
              state <= S_IDLE;
              irq_r <= 1'b1;
            end else begin
              bit_tmr <= bit_tmr - 32'd1;
            end
          end
          default: begin
            state   <= S_IDLE;
            tx_r    <= 1'b1;
            bit_tmr <= 32'd0;
          end
        endcase
      end
    end
  end

  assign tx         = tx_r;
  assign busy       = (state != S_IDLE);
  assign irq        = irq_r;
  assign o_tx_full  = fifo_full;
  assign o_tx_empty = fifo_empty;

endmodule

// File: tb/tb_uart_transmit.sv
// -----------------------------------------------------------------------------
// tb_uart_transmit
//   Directed stimulus pushes the expected frame (byte, bit time, irq after
//   the frame, whether the next frame follows without a gap) into a queue;
//   a monitor watches tx, pops an entry at each start bit and checks every
//   cycle of the frame plus the cycle after it.
// -----------------------------------------------------------------------------
module tb_uart_transmit;

  localparam int FIFO_DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] clk_div;
  logic [7:0]  tx_data;
  logic        i_tx_valid;
  logic        tx;
  logic        busy;
  logic        irq;
  logic        o_tx_full;
  logic        o_tx_empty;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         irq_after;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_busy = 0;

  uart_transmit #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_div    (clk_div),
    .tx_data    (tx_data),
    .i_tx_valid (i_tx_valid),
    .tx         (tx),
    .busy       (busy),
    .irq        (irq),
    .o_tx_full  (o_tx_full),
    .o_tx_empty (o_tx_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int div, input bit irq_a, input bit b2b);
    exp_t e;
    e.data = d;
    e.div = div;
    e.irq_after = irq_a;
    e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_data = d;
    i_tx_valid = 1'b1;
    @(posedge clk);
    #1;
    i_tx_valid = 1'b0;
  endtask

  // Count negedges with busy high, starting at the next negedge.
  task automatic measure_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !mon_busy && busy === 1'b0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected drained", name, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Frame monitor / scoreboard.
  initial begin : monitor
    exp_t       e;
    bit         pending;
    bit         aborted;
    int         bad;
    int         nb;
    int         n;
    logic [10:0] eb;
    logic [7:0] rx;
    pending = 0;
    forever begin
      if (!pending) @(negedge clk);
      pending = 0;
      if (rst_n === 1'b1 && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: tx low with nothing queued, expected idle high");
          n = 0;
          while (tx === 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          mon_busy = 1;
          e = exp_q.pop_front();
          eb = '1;
          eb[0] = 1'b0;
          eb[8:1] = e.data;
`ifdef UART_TX_PARITY_EN
          eb[9] = ^e.data;
          nb = 11;
`else
          nb = 10;
`endif
          bad = 0;
          aborted = 0;
          rx = '0;
          for (int b = 0; b < nb && !aborted; b++) begin
            for (int c = 0; c < e.div && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst_n !== 1'b1) begin
                aborted = 1;
              end else begin
                if (tx !== eb[b]) bad++;
                if (busy !== 1'b1) bad++;
                if (irq !== 1'b0) bad++;
                if (b >= 1 && b <= 8 && c == e.div / 2) rx[b-1] = tx;
              end
            end
          end
          if (aborted) begin
            exp_q.delete();
          end else begin
            checks++;
            if (rx !== e.data || bad != 0) begin
              errors++;
              $display("FAIL frame: got byte %0h with %0d bad cycles, expected byte %0h with 0 bad cycles",
                       rx, bad, e.data);
            end
            @(negedge clk);
            check("irq_after_frame", {31'd0, irq}, {31'd0, e.irq_after});
            check("line_after_frame", {31'd0, tx}, {31'd0, !e.b2b});
            if (rst_n === 1'b1 && tx === 1'b0) pending = 1;
          end
          mon_busy = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int lows;
    rst_n = 1'b0;
    i_tx_valid = 1'b0;
    tx_data = 8'h00;
    clk_div = 32'd4;
    #12;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_empty", {31'd0, o_tx_empty}, 32'd1);
    check("rst_full", {31'd0, o_tx_full}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0x55 at 4 cycles per bit.
    clk_div = 32'd4;
    push_exp(8'h55, 4, 1, 0);
    write_byte(8'h55);
    check("empty_after_write", {31'd0, o_tx_empty}, 32'd0);
    check("tx_before_start", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    check("tx_start_latency", {31'd0, tx}, 32'd0);
    check("busy_at_start", {31'd0, busy}, 32'd1);
    measure_busy(n);
    check("frame_len_55", n, 32'd40);
    wait_done("t55", 200);

    // Back-to-back 0xA3, 0x0F at 3 cycles per bit.
    clk_div = 32'd3;
    push_exp(8'hA3, 3, 0, 1);
    push_exp(8'h0F, 3, 1, 0);
    write_byte(8'hA3);
    write_byte(8'h0F);
    measure_busy(n);
    check("busy_b2b_len", n, 32'd60);
    wait_done("b2b", 300);

    // Divisor change mid-frame only affects the following frame.
    clk_div = 32'd4;
    push_exp(8'h3C, 4, 0, 1);
    push_exp(8'hC5, 8, 1, 0);
    write_byte(8'h3C);
    write_byte(8'hC5);
    repeat (10) @(posedge clk);
    #1;
    clk_div = 32'd8;
    wait_done("divchg", 400);

    // Divisor 0 behaves as 1.
    clk_div = 32'd0;
    push_exp(8'h81, 1, 1, 0);
    write_byte(8'h81);
    @(posedge clk);
    #1;
    measure_busy(n);
    check("div0_frame_len", n, 32'd10);
    wait_done("div0", 100);

    // Overfill: 10 writes while the first frame is stretched.
    clk_div = 32'd1000;
    push_exp(8'h10, 1000, 0, 1);
    for (int i = 1; i <= 7; i++) push_exp(8'h10 + 8'(i), 2, 0, 1);
    push_exp(8'h18, 2, 1, 0);
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      write_byte(8'h10 + 8'(i));
      if (i == 7) check("not_full_after_8", {31'd0, o_tx_full}, 32'd0);
      if (i == 8) check("full_after_9", {31'd0, o_tx_full}, 32'd1);
    end
    check("full_after_drop", {31'd0, o_tx_full}, 32'd1);
    clk_div = 32'd2;
    wait_done("full", 15000);
    check("empty_after_drain", {31'd0, o_tx_empty}, 32'd1);

    // Parity build: 0x07 has odd weight, so the even-parity bit is 1.
    clk_div = 32'd2;
    push_exp(8'h07, 2, 1, 0);
    write_byte(8'h07);
    @(posedge clk);
    #1;
    measure_busy(n);
`ifdef UART_TX_PARITY_EN
    check("frame_len_parity", n, 32'd22);
`else
    check("frame_len_noparity", n, 32'd20);
`endif
    wait_done("par", 100);

    // Reset during data bit 3 with three bytes still queued.
    clk_div = 32'd4;
    push_exp(8'hC1, 4, 0, 0);
    write_byte(8'hC1);
    write_byte(8'hC2);
    write_byte(8'hC3);
    write_byte(8'hC4);
    check("queued_before_reset", {31'd0, o_tx_empty}, 32'd0);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_empty", {31'd0, o_tx_empty}, 32'd1);
    check("abort_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("no_frames_after_abort", lows, 32'd0);

    // First edge after reset release accepts a write.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clk_div = 32'd2;
    push_exp(8'hE7, 2, 1, 0);
    write_byte(8'hE7);
    check("write_first_edge", {31'd0, o_tx_empty}, 32'd0);
    wait_done("post_rst", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmit.md
UART_TRANSMIT -- requirements
Module: uart_transmit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, minimum 2).
REQ-002 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port clk_div  input  32  clk cycles per UART bit.
REQ-005 SHALL have port tx_data  input  8  byte to enqueue.
REQ-006 SHALL have port i_tx_valid  input  1  one-cycle write strobe for tx_data.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port busy  output  1  frame in progress (start through stop bit).
REQ-009 SHALL have port irq  output  1  one-cycle pulse when transmission drains.
REQ-010 SHALL have port o_tx_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port o_tx_empty  output  1  FIFO holds zero entries.

Function
REQ-012 SHALL contain an internal FIFO: write when i_tx_valid=1 and count<FIFO_DEPTH; pop by FSM only; full/empty derived from registered count.
REQ-013 SHALL drop writes when o_tx_full=1, even if a pop occurs the same cycle; no other state changes.
REQ-014 SHALL accept a write and a pop in the same cycle when not full (count unchanged).
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY only when REQ-025 applies.
REQ-016 IDLE: tx=1, busy=0; if FIFO non-empty at a rising edge, pop head, latch byte and clk_div, go START, drive tx=0 on that edge.
REQ-017 Latency: byte written at edge N into empty FIFO while IDLE -> tx falls at edge N+1.
REQ-018 Each bit SHALL last exactly latched clk_div cycles; latched value 0 treated as 1.
REQ-019 DATA SHALL send 8 bits LSB first, bit index 0..7, then PARITY or STOP.
REQ-020 STOP: tx=1 for one bit time; at end, if FIFO non-empty pop and go directly to START (no idle gap), else go IDLE.
REQ-021 irq SHALL pulse high for exactly the one cycle after STOP completes with FIFO empty; never otherwise.
REQ-022 Changes to clk_div mid-frame SHALL take effect only at the next START.
REQ-023 busy SHALL be 1 in START, DATA, PARITY, STOP, and stay 1 across back-to-back frames.
REQ-024 Frame length SHALL be 10*clk_div cycles (11*clk_div with parity).

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, PARITY state sends even parity (XOR of 8 data bits) for one bit time between DATA and STOP; when undefined, PARITY state and logic absent, DATA goes directly to STOP.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, tx=1, busy=0, irq=0, FIFO count 0, o_tx_empty=1, o_tx_full=0, counters 0.
REQ-027 Reset mid-frame SHALL abort the frame; tx returns high immediately; queued bytes discarded.
REQ-028 After rst_n release, first write SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-029 clk_div=4, write 0x55 -> tx low 1 cycle after write, bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles, irq pulse 1 cycle, 40-cycle frame.
REQ-030 Write 0xA3, 0x0F back-to-back, clk_div=3 -> two frames contiguous, busy continuously 1 for 60 cycles, single irq after second stop.
REQ-031 Write FIFO_DEPTH+2 bytes while tx stalled by clk_div=1000 -> o_tx_full=1 after 8 accepted (first popped, so 9 total), extra dropped, only accepted bytes appear on tx.
REQ-032 Change clk_div 4->8 during DATA of first frame -> first frame keeps 4-cycle bits, second frame uses 8.
REQ-033 Assert rst_n=0 mid DATA bit 3 with 3 bytes queued -> tx=1, busy=0, o_tx_empty=1 immediately; no further frames.
REQ-034 With UART_TX_PARITY_EN, clk_div=2, write 0x07 -> parity bit 1, frame 22 cycles; without, frame 20 cycles.
